mu_sweep_ctrl: RTL and testbench
================================

Name: mu_sweep_ctrl

Overview:
- Next-generation sample/parameter sequencer for the chaos-map datapath.
- Replaces the fixed per-sample mu lookup and gated-divider clock with a parametrised controller.
- Two modes: preset mode (one mu from the built-in table) and sweep mode (mu stepped from start to end in fixed increments).
- For each mu it issues a programmable number of iteration strobes at a programmable rate, then advances. Output feeds the logistic-map calculator and the plot/capture logic.

Parameters:
- MU_W, 18, mu fixed-point width (2 integer + MU_W-2 fraction bits); must be >= 18.
- CNT_W, 13, width of iteration count / maxrepeat.
- DIV_W, 16, width of the rate divider.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-low reset.
- start  input  1  1-cycle pulse; accepted only in IDLE.
- abort  input  1  synchronous stop; overrides everything except RST.
- mode  input  1  0 = preset table, 1 = linear sweep; latched at start.
- sample_num  input  6  preset table index; latched at start.
- mu_start, mu_step, mu_end  input  MU_W each  sweep bounds and increment; latched at start.
- maxrepeat_in  input  CNT_W  iterations per mu; latched at start.
- div_ratio  input  DIV_W  strobe period minus 1; latched at start.
- mu  output  MU_W  current parameter.
- maxrepeat  output  CNT_W  latched iteration count (effective value).
- calc_en  output  1  iteration strobe (clock enable for the calculator).
- x_init  output  1  1-cycle pulse: calculator reloads initial x.
- iter_cnt  output  CNT_W  iterations issued for the current mu.
- busy  output  1  high outside IDLE.
- done  output  1  1-cycle pulse at normal completion.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; mu, maxrepeat, iter_cnt and divider counter all 0; calc_en, x_init, busy, done all 0.
- Preset table (values left-aligned to MU_W, LSBs zero-filled):
  - 0:0x0CCCC, 1:0x13333, 2:0x31999, 3:0x37333, 4:0x38CCD, 5:0x390A4
  - 6:0x390E5, 7:0x39127, 8:0x391EC, 9:0x3947B, 10:0x3FFFF
  - other indices: 0
- maxrepeat_in==0 is treated as 1; the maxrepeat output shows the effective value.
- State machine, all outputs registered:
  - IDLE: on start, latch all config inputs, go to LOAD. start while busy is ignored.
  - LOAD (1 cycle): mu <= mode ? mu_start : table[sample_num]; x_init=1 this cycle; clear iter_cnt and divider counter; go to RUN.
  - RUN:
    - Divider counts 0..div_ratio. calc_en=1 in the cycle the counter equals div_ratio, then the counter wraps to 0.
    - div_ratio=0 gives calc_en every cycle.
    - The first calc_en comes div_ratio+1 cycles after LOAD.
    - iter_cnt increments on each calc_en.
    - When calc_en fires with iter_cnt==maxrepeat-1, go to STEP; iter_cnt shows maxrepeat in STEP.
  - STEP (1 cycle), using a next value computed at MU_W+1 bits:
    - Go to DONE if mode==0, or the next value overflows MU_W bits, or the next value > mu_end (unsigned), or mu_step==0.
    - Otherwise mu <= next value and go to LOAD (so mu_end itself is included if reached exactly).
  - DONE (1 cycle): done=1; go to IDLE.
- mu holds its last value in IDLE until the next LOAD.
- mu_start > mu_end in sweep mode: that mu runs once, then DONE.
- abort in any non-IDLE state: next cycle state=IDLE, calc_en=0, x_init=0, done stays 0; mu and iter_cnt are frozen.
  - abort together with start in IDLE: start is ignored.
- busy=1 in LOAD, RUN, STEP and DONE.

Test Plan:
- Reset mid-RUN: assert RST low asynchronously -> all outputs 0 immediately, state IDLE; release, start works normally.
- Preset: mode=0, sample_num=4, maxrepeat_in=3, div_ratio=1 -> mu=0x38CCD, one x_init, calc_en on alternate cycles exactly 3 times, done 1 cycle after STEP; sample_num=20 -> mu=0.
- Sweep: mode=1, mu_start=0x30000, mu_step=0x04000, mu_end=0x38000, maxrepeat_in=2, div_ratio=0 -> mu visits 0x30000, 0x34000, 0x38000; 3 x_init pulses, 6 calc_en pulses, then done.
- Boundaries:
  - mu_start=0x3F000, mu_step=0x02000, mu_end=0x3FFFF -> overflow, single mu then done.
  - mu_step=0 -> single mu.
  - maxrepeat_in=0 -> exactly 1 calc_en.
- Abort: start a sweep, assert abort during 2nd mu -> busy falls next cycle, no done, no further calc_en; a new start restarts from mu_start.
- start pulsed while busy -> ignored; config changes after start do not affect the running sweep.

Source files
------------

// File: rtl/mu_sweep_ctrl.sv
// mu_sweep_ctrl: sample/parameter sequencer for the chaos-map datapath.
// Either plays one preset mu from the built-in table, or sweeps mu linearly
// from a start value to an end value. For every mu it reloads the calculator
// (x_init), then issues a fixed number of iteration strobes (calc_en) at a
// programmable rate before stepping to the next mu.
// Every output comes straight from a register.

module mu_sweep_ctrl #(
    parameter int MU_W  = 18,
    parameter int CNT_W = 13,
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [5:0]       sample_num,
    input  logic [MU_W-1:0]  mu_start,
    input  logic [MU_W-1:0]  mu_step,
    input  logic [MU_W-1:0]  mu_end,
    input  logic [CNT_W-1:0] maxrepeat_in,
    input  logic [DIV_W-1:0] div_ratio,
    output logic [MU_W-1:0]  mu,
    output logic [CNT_W-1:0] maxrepeat,
    output logic             calc_en,
    output logic             x_init,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Preset mu table; entries are 18-bit values left-aligned into MU_W bits.
    function automatic logic [MU_W-1:0] preset_mu(input logic [5:0] idx);
        logic [17:0] v;
        case (idx)
            6'd0:    v = 18'h0CCCC;
            6'd1:    v = 18'h13333;
            6'd2:    v = 18'h31999;
            6'd3:    v = 18'h37333;
            6'd4:    v = 18'h38CCD;
            6'd5:    v = 18'h390A4;
            6'd6:    v = 18'h390E5;
            6'd7:    v = 18'h39127;
            6'd8:    v = 18'h391EC;
            6'd9:    v = 18'h3947B;
            6'd10:   v = 18'h3FFFF;
            default: v = 18'h00000;
        endcase
        return MU_W'(v) << (MU_W - 18);
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;

    // configuration captured when a run is accepted
    logic             mode_r;
    logic [MU_W-1:0]  mu_step_r;
    logic [MU_W-1:0]  mu_end_r;
    logic [CNT_W-1:0] maxrep_r;
    logic [DIV_W-1:0] div_ratio_r;

    // registered outputs and working counters
    logic [MU_W-1:0]  mu_r;
    logic [CNT_W-1:0] iter_r;
    logic [DIV_W-1:0] div_r;
    logic             calc_en_r;
    logic             x_init_r;
    logic             busy_r;
    logic             done_r;

    // next-value signals
    logic [MU_W:0]    mu_sum_s;
    logic             step_stop_s;
    logic             last_iter_s;
    logic             accept_s;
    logic [MU_W-1:0]  mu_nxt_s;
    logic [CNT_W-1:0] iter_nxt_s;
    logic [DIV_W-1:0] div_nxt_s;
    logic             calc_en_nxt_s;

    // The next sweep value is formed one bit wider so overflow is visible.
    assign mu_sum_s    = {1'b0, mu_r} + {1'b0, mu_step_r};
    assign step_stop_s = ~mode_r | mu_sum_s[MU_W] |
                         (mu_sum_s[MU_W-1:0] > mu_end_r) |
                         (mu_step_r == {MU_W{1'b0}});
    assign last_iter_s = ((iter_r + CNT_W'(1'b1)) == maxrep_r);
    assign accept_s    = start & ~abort;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort returns to IDLE from any active state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_LOAD;
                else          state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                          state_nxt_s = ST_IDLE;
                else if (calc_en_r && last_iter_s)  state_nxt_s = ST_STEP;
                else                                state_nxt_s = ST_RUN;
            end
            ST_STEP: begin
                if (abort)            state_nxt_s = ST_IDLE;
                else if (step_stop_s) state_nxt_s = ST_DONE;
                else                  state_nxt_s = ST_LOAD;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values, derived from the current and next state.
    always_comb begin
        mu_nxt_s      = mu_r;
        iter_nxt_s    = iter_r;
        div_nxt_s     = div_r;
        calc_en_nxt_s = 1'b0;

        // mu is shown from the LOAD cycle of each parameter point
        if ((state_r == ST_IDLE) && (state_nxt_s == ST_LOAD)) begin
            mu_nxt_s = mode ? mu_start : preset_mu(sample_num);
        end else if ((state_r == ST_STEP) && (state_nxt_s == ST_LOAD)) begin
            mu_nxt_s = mu_sum_s[MU_W-1:0];
        end else begin
            mu_nxt_s = mu_r;
        end

        // counters restart on every LOAD and freeze on abort
        if (state_nxt_s == ST_LOAD) begin
            iter_nxt_s = {CNT_W{1'b0}};
            div_nxt_s  = {DIV_W{1'b0}};
        end else if ((state_r == ST_RUN) && (state_nxt_s != ST_IDLE)) begin
            if (calc_en_r) begin
                iter_nxt_s = iter_r + CNT_W'(1'b1);
                div_nxt_s  = {DIV_W{1'b0}};
            end else begin
                iter_nxt_s = iter_r;
                div_nxt_s  = div_r + DIV_W'(1'b1);
            end
        end else begin
            iter_nxt_s = iter_r;
            div_nxt_s  = div_r;
        end

        // strobe in the cycle where the divider sits at its terminal count
        if ((state_nxt_s == ST_RUN) && (div_nxt_s == div_ratio_r)) begin
            calc_en_nxt_s = 1'b1;
        end else begin
            calc_en_nxt_s = 1'b0;
        end
    end

    // Configuration capture when a run is accepted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mode_r      <= 1'b0;
            mu_step_r   <= {MU_W{1'b0}};
            mu_end_r    <= {MU_W{1'b0}};
            maxrep_r    <= {CNT_W{1'b0}};
            div_ratio_r <= {DIV_W{1'b0}};
        end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_LOAD)) begin
            mode_r      <= mode;
            mu_step_r   <= mu_step;
            mu_end_r    <= mu_end;
            maxrep_r    <= (maxrepeat_in == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : maxrepeat_in;
            div_ratio_r <= div_ratio;
        end
    end

    // Registered outputs and counters.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mu_r      <= {MU_W{1'b0}};
            iter_r    <= {CNT_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            calc_en_r <= 1'b0;
            x_init_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            mu_r      <= mu_nxt_s;
            iter_r    <= iter_nxt_s;
            div_r     <= div_nxt_s;
            calc_en_r <= calc_en_nxt_s;
            x_init_r  <= (state_nxt_s == ST_LOAD);
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    assign mu        = mu_r;
    assign maxrepeat = maxrep_r;
    assign calc_en   = calc_en_r;
    assign x_init    = x_init_r;
    assign iter_cnt  = iter_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_mu_sweep_ctrl.sv
// Self-checking bench for mu_sweep_ctrl: directed cases plus randomized runs,
// each compared cycle by cycle against a reference timeline built from the
// list of mu values a run must visit.

module tb_mu_sweep_ctrl;

    localparam int MU_W  = 18;
    localparam int CNT_W = 13;
    localparam int DIV_W = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             mode = 1'b0;
    logic [5:0]       sample_num = 6'd0;
    logic [MU_W-1:0]  mu_start = '0;
    logic [MU_W-1:0]  mu_step = '0;
    logic [MU_W-1:0]  mu_end = '0;
    logic [CNT_W-1:0] maxrepeat_in = '0;
    logic [DIV_W-1:0] div_ratio = '0;
    logic [MU_W-1:0]  mu;
    logic [CNT_W-1:0] maxrepeat;
    logic             calc_en;
    logic             x_init;
    logic [CNT_W-1:0] iter_cnt;
    logic             busy;
    logic             done;

    mu_sweep_ctrl #(.MU_W(MU_W), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .mode(mode),
        .sample_num(sample_num), .mu_start(mu_start), .mu_step(mu_step),
        .mu_end(mu_end), .maxrepeat_in(maxrepeat_in), .div_ratio(div_ratio),
        .mu(mu), .maxrepeat(maxrepeat), .calc_en(calc_en), .x_init(x_init),
        .iter_cnt(iter_cnt), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             calc;
        logic             xi;
        logic             dn;
        logic             bz;
        logic [CNT_W-1:0] it;
        logic [MU_W-1:0]  m;
    } exp_t;

    exp_t        expq[$];
    int          exp_maxrep;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] preset_tab [0:10];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference timeline: list the mu values, then lay out LOAD / RUN / STEP per mu.
    task automatic build_model(input logic md, input logic [5:0] idx,
                               input logic [MU_W-1:0] ms, input logic [MU_W-1:0] st,
                               input logic [MU_W-1:0] me, input logic [CNT_W-1:0] mr_in,
                               input logic [DIV_W-1:0] dv);
        logic [MU_W-1:0] mus[$];
        longint cur, nxt;
        int     m_eff, per;
        exp_t   e;
        expq.delete();
        m_eff = (mr_in == 0) ? 1 : int'(mr_in);
        exp_maxrep = m_eff;
        if (md)               cur = longint'(ms);
        else if (idx <= 6'd10) cur = longint'(preset_tab[idx]) << (MU_W - 18);
        else                  cur = 0;
        forever begin
            mus.push_back(cur[MU_W-1:0]);
            if (!md || st == 0 || mus.size() >= 64) break;
            nxt = cur + longint'(st);
            if (nxt >= (longint'(1) << MU_W) || nxt > longint'(me)) break;
            cur = nxt;
        end
        per = int'(dv) + 1;
        foreach (mus[k]) begin
            e.calc = 1'b0; e.xi = 1'b1; e.dn = 1'b0; e.bz = 1'b1; e.it = '0; e.m = mus[k];
            expq.push_back(e);
            for (int c = 1; c <= m_eff * per; c++) begin
                e.calc = ((c % per) == 0); e.xi = 1'b0; e.it = CNT_W'((c - 1) / per);
                expq.push_back(e);
            end
            e.calc = 1'b0; e.it = CNT_W'(m_eff);
            expq.push_back(e);
        end
        e.dn = 1'b1; expq.push_back(e);
        e.dn = 1'b0; e.bz = 1'b0; expq.push_back(e);
    endtask

    task automatic drive_cfg(input logic md, input logic [5:0] idx,
                             input logic [MU_W-1:0] ms, input logic [MU_W-1:0] st,
                             input logic [MU_W-1:0] me, input logic [CNT_W-1:0] mr,
                             input logic [DIV_W-1:0] dv);
        mode = md; sample_num = idx; mu_start = ms; mu_step = st; mu_end = me;
        maxrepeat_in = mr; div_ratio = dv;
    endtask

    task automatic scramble_inputs();
        mode         = 1'($urandom_range(0, 1));
        sample_num   = 6'($urandom_range(0, 63));
        mu_start     = MU_W'($urandom);
        mu_step      = MU_W'($urandom);
        mu_end       = MU_W'($urandom);
        maxrepeat_in = CNT_W'($urandom);
        div_ratio    = DIV_W'($urandom);
        start        = ($urandom_range(0, 3) == 0);
    endtask

    // Start a run with the currently driven config and check every cycle.
    task automatic run_txn(input string name, input int abort_at);
        exp_t e;
        logic [34:0] obs;
        build_model(mode, sample_num, mu_start, mu_step, mu_end, maxrepeat_in, div_ratio);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int t = 0; t < expq.size(); t++) begin
            e   = expq[t];
            obs = {calc_en, x_init, done, busy, iter_cnt, mu};
            check_val($sformatf("%s[%0d]", name, t), 64'(obs), 64'(e));
            if (t == abort_at) begin
                start = 1'b0;
                abort = 1'b1;
                @(negedge CLK);
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    obs = {calc_en, x_init, done, busy, iter_cnt, mu};
                    check_val($sformatf("%s_aborted[%0d]", name, k), 64'(obs),
                              64'({4'b0000, e.it, e.m}));
                    @(negedge CLK);
                end
                return;
            end
            if (t < expq.size() - 1) scramble_inputs();
            else                     start = 1'b0;
            @(negedge CLK);
        end
        check_val({name, "_maxrep"}, 64'(maxrepeat), 64'(exp_maxrep));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MU_W-1:0] ms, st, me;
        logic [31:0]     acc;
        preset_tab = '{18'h0CCCC, 18'h13333, 18'h31999, 18'h37333, 18'h38CCD, 18'h390A4,
                       18'h390E5, 18'h39127, 18'h391EC, 18'h3947B, 18'h3FFFF};

        // reset state
        #1 RST = 1'b0;
        #1 check_val("reset", 64'({calc_en, x_init, done, busy, iter_cnt, mu, maxrepeat}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // directed cases
        drive_cfg(1'b0, 6'd4, '0, '0, '0, 13'd3, 16'd1);
        run_txn("preset4", -1);
        drive_cfg(1'b0, 6'd20, '0, '0, '0, 13'd2, 16'd0);
        run_txn("preset20", -1);
        drive_cfg(1'b1, 6'd0, 18'h30000, 18'h04000, 18'h38000, 13'd2, 16'd0);
        run_txn("sweep", -1);
        drive_cfg(1'b1, 6'd0, 18'h3F000, 18'h02000, 18'h3FFFF, 13'd2, 16'd1);
        run_txn("overflow", -1);
        drive_cfg(1'b1, 6'd0, 18'h20000, 18'h00000, 18'h3FFFF, 13'd1, 16'd2);
        run_txn("step0", -1);
        drive_cfg(1'b1, 6'd0, 18'h20000, 18'h01000, 18'h20000, 13'd0, 16'd3);
        run_txn("maxrep0", -1);
        drive_cfg(1'b1, 6'd0, 18'h38000, 18'h01000, 18'h30000, 13'd1, 16'd0);
        run_txn("start_gt_end", -1);

        // abort during the second mu, then a clean restart from mu_start
        drive_cfg(1'b1, 6'd0, 18'h30000, 18'h04000, 18'h38000, 13'd2, 16'd1);
        run_txn("abort", 7);
        drive_cfg(1'b1, 6'd0, 18'h30000, 18'h04000, 18'h38000, 13'd2, 16'd1);
        run_txn("restart", -1);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        check_val("start_abort_idle", 64'({busy, x_init}), 64'd0);
        @(negedge CLK);
        check_val("start_abort_idle2", 64'({busy, x_init}), 64'd0);

        // asynchronous reset in the middle of RUN
        drive_cfg(1'b1, 6'd0, 18'h10000, 18'h01000, 18'h20000, 13'd4, 16'd2);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RST = 1'b0;
        #1 check_val("reset_midrun",
                     64'({calc_en, x_init, done, busy, iter_cnt, mu, maxrepeat}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        drive_cfg(1'b0, 6'd10, '0, '0, '0, 13'd2, 16'd1);
        run_txn("after_reset", -1);

        // randomized runs
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                drive_cfg(1'b0, 6'($urandom_range(0, 15)), MU_W'($urandom), MU_W'($urandom),
                          MU_W'($urandom), CNT_W'($urandom_range(0, 4)),
                          DIV_W'($urandom_range(0, 3)));
            end else begin
                st  = ($urandom_range(0, 7) == 0) ? '0 : MU_W'($urandom_range(1, 32'h8000));
                ms  = MU_W'($urandom_range(0, 32'h3FFFF));
                acc = 32'(ms) + 32'(st) * $urandom_range(0, 4) + $urandom_range(0, 32'(st));
                me  = acc[MU_W-1:0];
                drive_cfg(1'b1, 6'($urandom_range(0, 63)), ms, st, me,
                          CNT_W'($urandom_range(0, 4)), DIV_W'($urandom_range(0, 3)));
            end
            run_txn($sformatf("rand%0d", n), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
